// File: rtl/piezo_alert_sched_pkg.sv
// Shared types and constants for the piezo alert scheduler.
//   tune_t          tune selector presented to the tone player
//   state_t         scheduler FSM states
//   pick_tune()     fixed-priority requester encoder (FAST > BATT > STEER)
package piezo_alert_sched_pkg;

    typedef enum logic [1:0] {
        TuneNone  = 2'd0,
        TuneSteer = 2'd1,
        TuneBatt  = 2'd2,
        TuneFast  = 2'd3
    } tune_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPlay,
        StAbort,
        StAbortWait,
        StHoldoff
    } state_t;

    localparam int unsigned REPEAT_CLKS_DEF = 150_000_000;  // 3 s at 50 MHz
    localparam int unsigned FAST_SIM_STEP   = 64;
    localparam int unsigned CNT_W           = 28;

    function automatic tune_t pick_tune(logic fast, logic batt, logic steer);
        if (fast)       return TuneFast;
        else if (batt)  return TuneBatt;
        else if (steer) return TuneSteer;
        else            return TuneNone;
    endfunction

endpackage

// File: rtl/piezo_alert_sched_if.sv
// Request and tone-player handshake bundle for the alert scheduler.
//   too_fast, batt_low, en_steer   alert request levels
//   tune_busy, tune_done           player status (level, 1-clk pulse)
//   tune_start, tune_abort         player commands (1-clk pulses)
//   tune_sel                       selected tune, held while playing
//   alert_act                      scheduler is busy with an alert
// slave: the scheduler. master: the environment (requesters + player).
interface piezo_alert_sched_if;
    import piezo_alert_sched_pkg::*;

    logic  too_fast;
    logic  batt_low;
    logic  en_steer;
    logic  tune_busy;
    logic  tune_done;
    logic  tune_start;
    tune_t tune_sel;
    logic  tune_abort;
    logic  alert_act;

    modport slave (
        input  too_fast, batt_low, en_steer, tune_busy, tune_done,
        output tune_start, tune_sel, tune_abort, alert_act
    );

    modport master (
        output too_fast, batt_low, en_steer, tune_busy, tune_done,
        input  tune_start, tune_sel, tune_abort, alert_act
    );

endinterface

// File: rtl/alert_holdoff_tmr.sv
// Saturating repeat-holdoff counter.
//   clk, rst   clock, asynchronous active-high reset
//   clr        zero the counter (takes priority over en)
//   en         add step to the counter this clk
//   step       increment per enabled clk
//   expired    counter has reached LIMIT
// Reset preloads LIMIT so the first request after reset is not held off.
module alert_holdoff_tmr
    import piezo_alert_sched_pkg::*;
#(
    parameter int unsigned LIMIT = REPEAT_CLKS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] step,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + {1'b0, step};
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Carry out means the add would wrap: pin at all-ones instead.
            cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= CNT_W'(LIMIT);
        else     cnt_q <= cnt_d;
    end

    // >= rather than == since a step of 64 can jump past LIMIT.
    assign expired = (cnt_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/piezo_alert_sched.sv
// Alert scheduler for the shared piezo tone player.
//   clk, rst   clock, asynchronous active-high reset
//   bus        piezo_alert_sched_if.slave: alert requests in, player status in,
//              tune_start/tune_sel/tune_abort commands and alert_act out
// Arbitrates too_fast > batt_low > en_steer, enforces the repeat holdoff after
// non-FAST tunes and aborts a lower-priority tune when too_fast rises.
module piezo_alert_sched
    import piezo_alert_sched_pkg::*;
#(
    parameter bit          FAST_SIM    = 1'b0,
    parameter int unsigned REPEAT_CLKS = REPEAT_CLKS_DEF
) (
    input logic                 clk,
    input logic                 rst,
    piezo_alert_sched_if.slave  bus
);

    state_t           state_q, state_d;
    tune_t            sel_q, sel_d;
    logic             too_fast_q;
    logic             fast_rise;
    logic             expired;
    logic [CNT_W-1:0] step;

    assign fast_rise = bus.too_fast & ~too_fast_q;
    assign step      = FAST_SIM ? CNT_W'(FAST_SIM_STEP) : CNT_W'(1);

    // Holdoff runs from the end of a tune: cleared on START, frozen while
    // playing, counting in IDLE/HOLDOFF until it saturates.
    alert_holdoff_tmr #(
        .LIMIT (REPEAT_CLKS)
    ) u_holdoff (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == StStart),
        .en      ((state_q == StIdle) || (state_q == StHoldoff)),
        .step    (step),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.too_fast) begin
                    state_d = StStart;
                    sel_d   = TuneFast;
                end else if (expired && (bus.batt_low || bus.en_steer)) begin
                    state_d = StStart;
                    sel_d   = pick_tune(1'b0, bus.batt_low, bus.en_steer);
                end
            end
            StStart: state_d = StPlay;
            StPlay: begin
                if (bus.tune_done) begin
                    if (sel_q == TuneFast && bus.too_fast) begin
                        // Still over speed: repeat FAST straight away so the
                        // alert stays active without a gap through IDLE.
                        state_d = StStart;
                        sel_d   = TuneFast;
                    end else if (sel_q == TuneFast || fast_rise) begin
                        state_d = StIdle;
                        sel_d   = TuneNone;
                    end else begin
                        state_d = StHoldoff;
                    end
                end else if (fast_rise && sel_q != TuneFast) begin
                    state_d = StAbort;
                end
            end
            StAbort: state_d = StAbortWait;
            StAbortWait: begin
                if (!bus.tune_busy) begin
                    state_d = StStart;
                    sel_d   = TuneFast;
                end
            end
            StHoldoff: begin
                if (bus.too_fast) begin
                    state_d = StStart;
                    sel_d   = TuneFast;
                end else if (expired) begin
                    state_d = StIdle;
                    sel_d   = TuneNone;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = TuneNone;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= TuneNone;
            too_fast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            too_fast_q <= bus.too_fast;
        end
    end

    assign bus.tune_start = (state_q == StStart);
    assign bus.tune_abort = (state_q == StAbort);
    assign bus.tune_sel   = sel_q;
    assign bus.alert_act  = !((state_q == StIdle) || (state_q == StHoldoff));

endmodule
